tcdm_bus_error_monitor: RTL and testbench

Passive monitor on one TCDM master port, placed between a core/DMA master and the SoC interconnect. It pairs each response with the request that caused it, and captures the address and direction of the first access that returns r_opc=1. Bus errors come from the error slave behind the address decoder. The block raises an interrupt and exposes sticky status to a register file; it never drives the bus.

---
 rtl/tcdm_bus_error_monitor.sv | 178 +++++++++++++++++
 tb/tb_tcdm_bus_error_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bus_error_monitor.sv
// Passive TCDM error monitor: pairs in-order responses with their accepted requests
// and captures the first erroring access, with sticky status, a saturating count and an IRQ pulse.
module tcdm_bus_error_monitor #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 8,
  parameter bit          CHECK_PROTO     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  gnt_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic                  r_valid_i,
  input  logic                  r_opc_i,
  input  logic                  clear_i,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  err_write_o,
  output logic                  err_multi_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic                  proto_err_o,
  output logic                  irq_o
);

  localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0]      fifo_addr_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_wr_q;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]          fill_q, fill_d;

  logic                  err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  err_write_q, err_write_d;
  logic                  err_multi_q, err_multi_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d, cnt_base_s;
  logic                  proto_q, proto_d;
  logic                  irq_q, irq_d;

  logic empty_s, full_s, accept_s, push_s, pop_s;
  logic underflow_s, overflow_s, err_resp_s, held_valid_s;

  assign empty_s     = (fill_q == FILL_W'(0));
  assign full_s      = (fill_q == FILL_W'(MAX_OUTSTANDING));
  assign accept_s    = req_i & gnt_i;
  // The pop never sees a same-cycle push, so an empty FIFO always means underflow.
  assign pop_s       = r_valid_i & ~empty_s;
  assign push_s      = accept_s & (~full_s | pop_s);
  assign underflow_s = r_valid_i & empty_s;
  assign overflow_s  = accept_s & full_s & ~pop_s;
  assign err_resp_s  = pop_s & r_opc_i;
  assign held_valid_s = err_valid_q & ~clear_i;

  // FIFO pointer and fill-level next state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Sticky status next state; an error coinciding with clear is captured as a first error.
  always_comb begin
    err_valid_d = held_valid_s;
    err_multi_d = err_multi_q & ~clear_i;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    proto_d     = (proto_q & ~clear_i) | underflow_s | overflow_s;
    irq_d       = 1'b0;
    cnt_base_s  = clear_i ? '0 : err_cnt_q;
    if (r_valid_i && r_opc_i && (cnt_base_s != {CNT_WIDTH{1'b1}})) begin
      err_cnt_d = cnt_base_s + CNT_WIDTH'(1);
    end else begin
      err_cnt_d = cnt_base_s;
    end
    if (err_resp_s) begin
      if (!held_valid_s) begin
        err_valid_d = 1'b1;
        err_addr_d  = fifo_addr_q[rd_ptr_q];
        err_write_d = fifo_wr_q[rd_ptr_q];
        irq_d       = 1'b1;
      end else begin
        err_multi_d = 1'b1;
      end
    end else begin
      irq_d = 1'b0;
    end
  end

  // In-flight request storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_addr_q[i] <= '0;
      end
      fifo_wr_q <= '0;
    end else if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= add_i;
      fifo_wr_q[wr_ptr_q]   <= ~wen_i;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_multi_q <= 1'b0;
      err_cnt_q   <= '0;
      proto_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_multi_q <= err_multi_d;
      err_cnt_q   <= err_cnt_d;
      proto_q     <= proto_d;
      irq_q       <= irq_d;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_write_o = err_write_q;
  assign err_multi_o = err_multi_q;
  assign err_cnt_o   = err_cnt_q;
  assign proto_err_o = proto_q;
  assign irq_o       = irq_q;

  // Protocol checker; disabled by default since a violating bus is a reportable condition here.
  if (CHECK_PROTO) begin : g_chk
    tcdm_bus_error_monitor_chk u_chk (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .r_valid_i (r_valid_i),
      .empty_i   (empty_s)
    );
  end

endmodule

// Flags a response observed while nothing is outstanding.
module tcdm_bus_error_monitor_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic r_valid_i,
  input logic empty_i
);

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_valid_i && empty_i))
    else $error("response with no outstanding request");

endmodule

// File: tb/tb_tcdm_bus_error_monitor.sv
// Directed bench for tcdm_bus_error_monitor with a queue-based reference model checked every cycle.
module tb_tcdm_bus_error_monitor;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, gnt_i = 1'b0, wen_i = 1'b1;
  logic [31:0] add_i = 32'h0;
  logic        r_valid_i = 1'b0, r_opc_i = 1'b0, clear_i = 1'b0;
  logic        err_valid_o, err_write_o, err_multi_o, proto_err_o, irq_o;
  logic [31:0] err_addr_o;
  logic [7:0]  err_cnt_o;

  always #5 clk_i = ~clk_i;

  tcdm_bus_error_monitor dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_i(gnt_i), .add_i(add_i),
    .wen_i(wen_i), .r_valid_i(r_valid_i), .r_opc_i(r_opc_i), .clear_i(clear_i),
    .err_valid_o(err_valid_o), .err_addr_o(err_addr_o), .err_write_o(err_write_o),
    .err_multi_o(err_multi_o), .err_cnt_o(err_cnt_o), .proto_err_o(proto_err_o), .irq_o(irq_o)
  );

  int checks = 0;
  int errors = 0;
  int irq_seen = 0;
  int irq_base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outstanding requests as a queue, status as plain variables.
  typedef struct {logic [31:0] a; logic w;} ent_t;
  ent_t        q[$];
  ent_t        e;
  int          n0;
  logic        m_valid = 1'b0, m_write = 1'b0, m_multi = 1'b0, m_proto = 1'b0, m_irq = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [7:0]  m_cnt = 8'h0;

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      q.delete();
      m_valid = 1'b0; m_write = 1'b0; m_multi = 1'b0; m_proto = 1'b0; m_irq = 1'b0;
      m_addr = 32'h0; m_cnt = 8'h0;
    end else begin
      n0 = q.size();
      m_irq = 1'b0;
      if (clear_i) begin
        m_valid = 1'b0; m_multi = 1'b0; m_cnt = 8'h0; m_proto = 1'b0;
      end
      if (r_valid_i) begin
        if (n0 == 0) begin
          m_proto = 1'b1;
        end else begin
          e = q.pop_front();
          if (r_opc_i) begin
            if (!m_valid) begin
              m_valid = 1'b1; m_addr = e.a; m_write = e.w; m_irq = 1'b1;
            end else begin
              m_multi = 1'b1;
            end
          end
        end
        if (r_opc_i && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      if (req_i && gnt_i) begin
        if (q.size() < 4) q.push_back('{a: add_i, w: ~wen_i});
        else m_proto = 1'b1;
      end
    end
  end

  always @(negedge clk_i) begin
    chk("err_valid", {63'h0, err_valid_o}, {63'h0, m_valid});
    chk("err_addr",  {32'h0, err_addr_o},  {32'h0, m_addr});
    chk("err_write", {63'h0, err_write_o}, {63'h0, m_write});
    chk("err_multi", {63'h0, err_multi_o}, {63'h0, m_multi});
    chk("err_cnt",   {56'h0, err_cnt_o},   {56'h0, m_cnt});
    chk("proto_err", {63'h0, proto_err_o}, {63'h0, m_proto});
    chk("irq",       {63'h0, irq_o},       {63'h0, m_irq});
    if (irq_o) irq_seen++;
  end

  task automatic cyc(input logic rq, input logic gn, input logic [31:0] a, input logic w,
                     input logic rv, input logic opc, input logic clr);
    req_i = rq; gnt_i = gn; add_i = a; wen_i = w;
    r_valid_i = rv; r_opc_i = opc; clear_i = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Idle after reset
    idle(10);
    chk("t1_irq_never", 64'(irq_seen), 64'd0);
    chk("t1_valid", {63'h0, err_valid_o}, 64'd0);
    chk("t1_cnt", {56'h0, err_cnt_o}, 64'd0);

    // Single read error
    irq_base = irq_seen;
    cyc(1'b1, 1'b1, 32'h1A10_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_valid", {63'h0, err_valid_o}, 64'd1);
    chk("t2_addr", {32'h0, err_addr_o}, 64'h1A10_0000);
    chk("t2_write", {63'h0, err_write_o}, 64'd0);
    chk("t2_cnt", {56'h0, err_cnt_o}, 64'd1);
    chk("t2_irq_hi", {63'h0, irq_o}, 64'd1);
    idle(2);
    chk("t2_irq_lo", {63'h0, irq_o}, 64'd0);
    chk("t2_irq_once", 64'(irq_seen - irq_base), 64'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_clear_valid", {63'h0, err_valid_o}, 64'd0);
    chk("t2_clear_addr_held", {32'h0, err_addr_o}, 64'h1A10_0000);

    // Back-to-back with simultaneous push/pop; an ungranted request must not enter the FIFO
    irq_base = irq_seen;
    cyc(1'b1, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("t3_addr", {32'h0, err_addr_o}, 64'h200);
    chk("t3_write", {63'h0, err_write_o}, 64'd1);
    chk("t3_multi", {63'h0, err_multi_o}, 64'd1);
    chk("t3_cnt", {56'h0, err_cnt_o}, 64'd2);
    chk("t3_irq_once", 64'(irq_seen - irq_base), 64'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Overflow: fifth accept is dropped
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 32'(i * 32'h1000), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_proto", {63'h0, proto_err_o}, 64'd1);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("t4_addr", {32'h0, err_addr_o}, 64'h4000);
    chk("t4_valid", {63'h0, err_valid_o}, 64'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Underflow, then clear coincident with underflow, then plain clear
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_proto", {63'h0, proto_err_o}, 64'd1);
    chk("t5_valid", {63'h0, err_valid_o}, 64'd0);
    chk("t5_cnt", {56'h0, err_cnt_o}, 64'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_proto_clr_wins", {63'h0, proto_err_o}, 64'd1);
    chk("t5_cnt_clr", {56'h0, err_cnt_o}, 64'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_proto_cleared", {63'h0, proto_err_o}, 64'd0);

    // 300 errors saturate the counter; then clear coincident with an error
    cyc(1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 300; i++) cyc(1'b1, 1'b1, 32'(i), 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("t6_cnt_sat", {56'h0, err_cnt_o}, 64'd255);
    chk("t6_multi", {63'h0, err_multi_o}, 64'd1);
    chk("t6_addr", {32'h0, err_addr_o}, 64'h8000_0000);
    irq_base = irq_seen;
    cyc(1'b1, 1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6_clr_cnt", {56'h0, err_cnt_o}, 64'd1);
    chk("t6_clr_multi", {63'h0, err_multi_o}, 64'd0);
    chk("t6_clr_valid", {63'h0, err_valid_o}, 64'd1);
    chk("t6_clr_addr", {32'h0, err_addr_o}, 64'hCAFE_0000);
    chk("t6_clr_write", {63'h0, err_write_o}, 64'd1);
    idle(2);
    chk("t6_irq_once", 64'(irq_seen - irq_base), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
